// File: rtl/psram_ctrl_if.sv
// psram_ctrl_if
// Request/response bundle between the SoC bus bridge and psram_ctrl.
//   req_valid/req_ready  request handshake
//   req_we               1 = write, 0 = read
//   req_addr             24-bit byte address
//   req_size             0 = 1 B, 1 = 2 B, 2/3 = 4 B
//   req_wdata            little-endian write data
//   rsp_valid            one-cycle response strobe (no backpressure)
//   rsp_rdata            little-endian read data, upper unused bytes 0
//   rsp_err              error flag, qualified by rsp_valid
// Modports: master = bus bridge side, slave = controller side.
interface psram_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [23:0] req_addr;
  logic [1:0]  req_size;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/psram_ctrl.sv
// psram_ctrl
// Bus-side master for the QSPI PSRAM. Each accepted request is serialised as
// 8 command bits on dio[0], six address nibbles, then two nibbles per data
// byte (high nibble first), followed by a one-cycle response.
// Ports:
//   clock, reset_n      system clock, async active-low reset
//   bus (slave)         request/response bundle, see psram_ctrl_if
//   psram_sck           serial clock (registered)
//   psram_ce_n          chip enable, active low (registered)
//   psram_dio_out/_oe   pin drive data and per-pin output enable (registered)
//   psram_dio_in        pin sample data
// Parameter CLK_DIV (1..8): sck half-period in clock cycles.
// Optional feature: define PSRAM_CTRL_RANGE_CHECK_EN to reject requests
// outside 4 MiB or misaligned to their size (rsp_err = 1, no pin activity).
module psram_ctrl #(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic         clock,
  input  logic         reset_n,
  psram_ctrl_if.slave  bus,
  output logic         psram_sck,
  output logic         psram_ce_n,
  output logic [3:0]   psram_dio_out,
  output logic [3:0]   psram_dio_oe,
  input  logic [3:0]   psram_dio_in
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD  = 3'd1,
    ADDR = 3'd2,
    DATA = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [2:0] HALF_LAST = 3'(CLK_DIV - 1);

  state_t      state, state_nxt;
  logic [2:0]  div_cnt, div_nxt;
  logic [4:0]  pulse, pulse_nxt;
  logic        sck, sck_nxt;
  logic        ce_n, ce_n_nxt;
  logic [3:0]  dio_out, dio_out_nxt;
  logic [3:0]  oe, oe_nxt;
  logic        we_q, we_nxt;
  logic [23:0] addr_q, addr_nxt;
  logic [31:0] wdata_q, wdata_nxt;
  logic [4:0]  last_q, last_nxt;
  logic [31:0] rdata_q, rdata_nxt;
  logic        rsp_valid, rsp_valid_nxt;
  logic [31:0] rsp_rdata, rsp_rdata_nxt;
  logic        rsp_err, rsp_err_nxt;
  logic        ready, ready_nxt;
  logic        rej_pend, rej_pend_nxt;
  logic        reject;
  logic        start_unit;
  logic [4:0]  term;

  // Nibble driven on dio_out for a given protocol unit.
  function automatic logic [3:0] unit_nibble(input state_t st, input logic [4:0] p,
                                             input logic we, input logic [23:0] a,
                                             input logic [31:0] wd);
    logic [7:0] cmd;
    logic [7:0] byte_v;
    cmd         = we ? 8'h38 : 8'hEB;
    byte_v      = 8'(wd >> {p[2:1], 3'b000});
    unit_nibble = 4'h0;
    case (st)
      CMD:     unit_nibble = {3'b000, cmd[3'd7 - p[2:0]]};
      ADDR:    unit_nibble = 4'(a >> (5'd20 - {p[2:0], 2'b00}));
      DATA:    unit_nibble = we ? (p[0] ? byte_v[3:0] : byte_v[7:4]) : 4'h0;
      default: unit_nibble = 4'h0;
    endcase
  endfunction

  // Output-enable pattern for a given protocol unit.
  function automatic logic [3:0] unit_oe(input state_t st, input logic we);
    case (st)
      CMD:     unit_oe = 4'b0001;
      ADDR:    unit_oe = 4'b1111;
      DATA:    unit_oe = we ? 4'b1111 : 4'b0000;
      default: unit_oe = 4'b0000;
    endcase
  endfunction

`ifdef PSRAM_CTRL_RANGE_CHECK_EN
  // Request rejection: outside 4 MiB or misaligned to its size.
  always_comb begin
    reject = (bus.req_addr[23:22] != 2'b00);
    case (bus.req_size)
      2'd0:    reject = reject;
      2'd1:    reject = reject | bus.req_addr[0];
      default: reject = reject | (bus.req_addr[1:0] != 2'b00);
    endcase
  end
`else
  assign reject = 1'b0;
`endif

  // Next-state and next-output logic for the transfer FSM.
  always_comb begin
    state_nxt     = state;
    div_nxt       = div_cnt;
    pulse_nxt     = pulse;
    sck_nxt       = sck;
    ce_n_nxt      = ce_n;
    dio_out_nxt   = dio_out;
    oe_nxt        = oe;
    we_nxt        = we_q;
    addr_nxt      = addr_q;
    wdata_nxt     = wdata_q;
    last_nxt      = last_q;
    rdata_nxt     = rdata_q;
    rsp_valid_nxt = 1'b0;
    rsp_rdata_nxt = rsp_rdata;
    rsp_err_nxt   = rsp_err;
    rej_pend_nxt  = rej_pend;
    start_unit    = 1'b0;

    case (state)
      CMD:     term = 5'd7;
      ADDR:    term = 5'd5;
      default: term = last_q;
    endcase

    case (state)
      IDLE: begin
        if (rej_pend) begin
          // Rejected request: respond without touching the pins.
          state_nxt     = DONE;
          rsp_valid_nxt = 1'b1;
          rsp_err_nxt   = 1'b1;
          rsp_rdata_nxt = 32'h0;
          rej_pend_nxt  = 1'b0;
        end else if (bus.req_valid && ready) begin
          we_nxt    = bus.req_we;
          addr_nxt  = bus.req_addr;
          wdata_nxt = bus.req_wdata;
          rdata_nxt = 32'h0;
          case (bus.req_size)
            2'd0:    last_nxt = 5'd1;
            2'd1:    last_nxt = 5'd3;
            default: last_nxt = 5'd7;
          endcase
          if (reject) begin
            rej_pend_nxt = 1'b1;
          end else begin
            state_nxt  = CMD;
            ce_n_nxt   = 1'b0;
            sck_nxt    = 1'b0;
            div_nxt    = 3'd0;
            pulse_nxt  = 5'd0;
            start_unit = 1'b1;
          end
        end else begin
          state_nxt = IDLE;
        end
      end

      CMD, ADDR, DATA: begin
        if (div_cnt != HALF_LAST) begin
          div_nxt = div_cnt + 3'd1;
        end else begin
          div_nxt = 3'd0;
          if (!sck) begin
            // Rising edge: sample the device before it advances.
            sck_nxt = 1'b1;
            if (state == DATA && !we_q) begin
              rdata_nxt = rdata_q | (32'(psram_dio_in) << {pulse[2:1], ~pulse[0], 2'b00});
            end else begin
              rdata_nxt = rdata_q;
            end
          end else begin
            // Falling edge: start the next unit's low half.
            sck_nxt = 1'b0;
            if (pulse != term) begin
              pulse_nxt  = pulse + 5'd1;
              start_unit = 1'b1;
            end else begin
              case (state)
                CMD: begin
                  state_nxt  = ADDR;
                  pulse_nxt  = 5'd0;
                  start_unit = 1'b1;
                end
                ADDR: begin
                  state_nxt  = DATA;
                  pulse_nxt  = 5'd0;
                  start_unit = 1'b1;
                end
                default: begin
                  state_nxt     = DONE;
                  ce_n_nxt      = 1'b1;
                  oe_nxt        = 4'b0000;
                  dio_out_nxt   = 4'h0;
                  rsp_valid_nxt = 1'b1;
                  rsp_err_nxt   = 1'b0;
                  rsp_rdata_nxt = we_q ? 32'h0 : rdata_q;
                end
              endcase
            end
          end
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (start_unit) begin
      dio_out_nxt = unit_nibble(state_nxt, pulse_nxt, we_nxt, addr_nxt, wdata_nxt);
      oe_nxt      = unit_oe(state_nxt, we_nxt);
    end else begin
      dio_out_nxt = dio_out_nxt;
    end

    ready_nxt = (state_nxt == IDLE) && !rej_pend_nxt;
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      div_cnt   <= 3'd0;
      pulse     <= 5'd0;
      sck       <= 1'b0;
      ce_n      <= 1'b1;
      dio_out   <= 4'h0;
      oe        <= 4'h0;
      we_q      <= 1'b0;
      addr_q    <= 24'h0;
      wdata_q   <= 32'h0;
      last_q    <= 5'd0;
      rdata_q   <= 32'h0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      ready     <= 1'b1;
      rej_pend  <= 1'b0;
    end else begin
      state     <= state_nxt;
      div_cnt   <= div_nxt;
      pulse     <= pulse_nxt;
      sck       <= sck_nxt;
      ce_n      <= ce_n_nxt;
      dio_out   <= dio_out_nxt;
      oe        <= oe_nxt;
      we_q      <= we_nxt;
      addr_q    <= addr_nxt;
      wdata_q   <= wdata_nxt;
      last_q    <= last_nxt;
      rdata_q   <= rdata_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_rdata <= rsp_rdata_nxt;
      rsp_err   <= rsp_err_nxt;
      ready     <= ready_nxt;
      rej_pend  <= rej_pend_nxt;
    end
  end

  assign bus.req_ready  = ready;
  assign bus.rsp_valid  = rsp_valid;
  assign bus.rsp_rdata  = rsp_rdata;
  assign bus.rsp_err    = rsp_err;
  assign psram_sck      = sck;
  assign psram_ce_n     = ce_n;
  assign psram_dio_out  = dio_out;
  assign psram_dio_oe   = oe;

endmodule

// File: tb/tb_psram_ctrl.sv
// tb_psram_ctrl
// Scoreboard bench for psram_ctrl: a behavioural PSRAM device on the pins,
// a reference byte memory, and a queue of expected responses.
`timescale 1ns/1ps
module tb_psram_ctrl;
  localparam int D = 1;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b1;
  logic       psram_sck, psram_ce_n;
  logic [3:0] psram_dio_out, psram_dio_oe, psram_dio_in;

  int checks = 0, failures = 0, cyc = 0;

  psram_ctrl_if bus();

  psram_ctrl #(.CLK_DIV(D)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .bus           (bus),
    .psram_sck     (psram_sck),
    .psram_ce_n    (psram_ce_n),
    .psram_dio_out (psram_dio_out),
    .psram_dio_oe  (psram_dio_oe),
    .psram_dio_in  (psram_dio_in)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural device ----------------
  logic [7:0]  dev_mem [0:1023];
  logic [7:0]  ref_mem [0:1023];
  int          cnt = 0, ce_falls = 0;
  logic [7:0]  cap_cmd = 8'h0;
  logic [23:0] cap_addr = 24'h0;
  logic [31:0] cap_wdata = 32'h0;
  logic        oe_bad = 1'b0;

  always @(posedge psram_sck or negedge psram_ce_n) begin
    int k;
    if (!psram_sck) begin
      cnt       <= 0;
      cap_cmd   <= 8'h0;
      cap_addr  <= 24'h0;
      cap_wdata <= 32'h0;
      oe_bad    <= 1'b0;
      ce_falls  <= ce_falls + 1;
    end else begin
      k = cnt - 14;
      if (cnt < 8) begin
        cap_cmd <= {cap_cmd[6:0], psram_dio_out[0]};
        if (psram_dio_oe !== 4'b0001 || psram_dio_out[3:1] !== 3'b000) oe_bad <= 1'b1;
      end else if (cnt < 14) begin
        cap_addr <= {cap_addr[19:0], psram_dio_out};
        if (psram_dio_oe !== 4'b1111) oe_bad <= 1'b1;
      end else if (cap_cmd == 8'h38) begin
        if (psram_dio_oe !== 4'b1111) oe_bad <= 1'b1;
        if (k[0]) dev_mem[10'(cap_addr[9:0] + 10'(k / 2))][3:0] <= psram_dio_out;
        else      dev_mem[10'(cap_addr[9:0] + 10'(k / 2))][7:4] <= psram_dio_out;
        if (k < 8) cap_wdata[8 * (k / 2) + (k[0] ? 0 : 4) +: 4] <= psram_dio_out;
      end else begin
        if (psram_dio_oe !== 4'b0000) oe_bad <= 1'b1;
      end
      cnt <= cnt + 1;
    end
  end

  logic [3:0] rd_nib;
  logic [7:0] rd_byte;
  int         rd_k;
  always_comb begin
    rd_k    = cnt - 14;
    rd_byte = 8'h00;
    rd_nib  = 4'h0;
    if (cnt >= 14) begin
      rd_byte = dev_mem[10'(cap_addr[9:0] + 10'(rd_k / 2))];
      rd_nib  = rd_k[0] ? rd_byte[3:0] : rd_byte[7:4];
    end
  end
  assign psram_dio_in = rd_nib;

  // ---------------- scoreboard ----------------
  typedef struct {
    logic        we;
    logic [23:0] addr;
    int          bytes;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          hs_cyc;
    int          exp_lat;
    int          falls;
  } txn_t;
  txn_t sbq[$];

  int last_rsp = 0, prev_rsp = 0, last_hs = 0, hi_run = 0, last_gap = 0;

  task automatic score_rsp();
    txn_t t;
    logic [31:0] wmask;
    if (sbq.size() == 0) begin
      check("rsp_unexpected", 32'd1, 32'd0);
    end else begin
      t = sbq.pop_front();
      check("rdata", bus.rsp_rdata, t.exp_rdata);
      check("err", 32'(bus.rsp_err), 32'(t.exp_err));
      check("latency", cyc - t.hs_cyc, t.exp_lat);
      if (t.exp_err) begin
        check("ce_quiet", ce_falls, t.falls);
      end else begin
        check("cmd", 32'(cap_cmd), t.we ? 32'h38 : 32'hEB);
        check("addr", 32'(cap_addr), 32'(t.addr));
        check("pulses", cnt, 14 + 2 * t.bytes);
        check("oe_pattern", 32'(oe_bad), 32'd0);
        if (t.we) begin
          wmask = (t.bytes == 4) ? 32'hFFFFFFFF : ((32'd1 << (8 * t.bytes)) - 32'd1);
          check("wdata_pins", cap_wdata, t.wdata & wmask);
        end
      end
    end
  endtask

  always @(negedge clock) begin
    if (psram_ce_n === 1'b1) begin
      hi_run <= hi_run + 1;
    end else begin
      if (hi_run != 0) last_gap <= hi_run;
      hi_run <= 0;
    end
    if (bus.rsp_valid === 1'b1) begin
      prev_rsp <= last_rsp;
      last_rsp <= cyc;
      score_rsp();
    end
  end

  // Drive one request (called at a negedge); returns after the handshake edge.
  task automatic send(input logic we, input logic [23:0] a, input logic [1:0] sz,
                      input logic [31:0] wd, input bit keep);
    txn_t t;
    int   w;
    int   nb;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_size  = sz;
    bus.req_wdata = wd;
    w = 0;
    while (bus.req_ready !== 1'b1 && w < 500) begin
      @(negedge clock);
      w++;
    end
    if (w >= 500) begin
      check("ready_timeout", 32'd0, 32'd1);
    end else begin
      nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      t.we = we; t.addr = a; t.bytes = nb; t.wdata = wd;
      t.exp_err = 1'b0;
      t.exp_rdata = 32'h0;
`ifdef PSRAM_CTRL_RANGE_CHECK_EN
      if (a[23:22] != 2'b00 || (nb == 2 && a[0]) || (nb == 4 && a[1:0] != 2'b00)) t.exp_err = 1'b1;
`endif
      if (t.exp_err) begin
        t.exp_lat = 1;
      end else begin
        t.exp_lat = 2 * (14 + 2 * nb) * D;
        for (int i = 0; i < nb; i++) begin
          if (we) ref_mem[10'(a[9:0] + 10'(i))] = wd[8 * i +: 8];
          else    t.exp_rdata[8 * i +: 8] = ref_mem[10'(a[9:0] + 10'(i))];
        end
      end
      t.hs_cyc = cyc + 1;
      t.falls  = ce_falls;
      last_hs  = cyc + 1;
      sbq.push_back(t);
    end
    @(negedge clock);
    if (!keep) bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sbq.size() != 0 && w < 2000) begin
      @(negedge clock);
      w++;
    end
    if (w >= 2000) begin
      check("drain_timeout", 32'(sbq.size()), 32'd0);
      sbq.delete();
    end
    @(negedge clock);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    for (int i = 0; i < 1024; i++) begin
      dev_mem[i] <= 8'(i * 7 + 3);
      ref_mem[i] = 8'(i * 7 + 3);
    end
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = 24'h0;
    bus.req_size  = 2'd0;
    bus.req_wdata = 32'h0;

    #1 reset_n = 1'b0;
    #2;
    check("reset_pins",
          32'({psram_sck, psram_ce_n, psram_dio_out, psram_dio_oe, bus.rsp_valid, bus.rsp_err, bus.req_ready}),
          32'({1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1}));
    check("reset_rdata", bus.rsp_rdata, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Basic write then reads of the same bytes.
    send(1'b1, 24'h000100, 2'd2, 32'h11223344, 1'b0);
    drain();
    send(1'b0, 24'h000100, 2'd2, 32'h0, 1'b0);
    send(1'b0, 24'h000102, 2'd0, 32'h0, 1'b0);
    send(1'b0, 24'h000100, 2'd1, 32'h0, 1'b0);
    drain();

    // Back-to-back with req_valid held high.
    send(1'b1, 24'h000200, 2'd1, 32'hDEADBEEF, 1'b1);
    send(1'b0, 24'h000200, 2'd1, 32'h0, 1'b0);
    drain();
    check("b2b_hs_gap", last_hs - prev_rsp, 32'd2);
    check("b2b_ce_gap", last_gap, 32'd2);

    // Size 3 behaves as 4 bytes; 1-byte write at a page-odd address.
    send(1'b1, 24'h000300, 2'd3, 32'hA5C3_0F96, 1'b0);
    send(1'b1, 24'h0003FF, 2'd0, 32'h0000_007E, 1'b0);
    send(1'b0, 24'h000300, 2'd3, 32'h0, 1'b0);
    send(1'b0, 24'h0003FC, 2'd2, 32'h0, 1'b0);
    drain();

    // Misaligned 4-byte access and out-of-range address.
    send(1'b0, 24'h000002, 2'd2, 32'h0, 1'b0);
`ifdef PSRAM_CTRL_RANGE_CHECK_EN
    send(1'b0, 24'h400000, 2'd0, 32'h0, 1'b0);
    send(1'b1, 24'h000101, 2'd1, 32'h0000_1234, 1'b0);
`endif
    drain();

    // Reset in the middle of the address phase.
    send(1'b0, 24'h000100, 2'd2, 32'h0, 1'b0);
    w = 0;
    while (cnt < 10 && w < 100) begin
      @(negedge clock);
      w++;
    end
    check("abort_reach_addr", 32'(w < 100), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("abort_pins",
          32'({psram_sck, psram_ce_n, psram_dio_oe, bus.rsp_valid, bus.req_ready}),
          32'({1'b0, 1'b1, 4'h0, 1'b0, 1'b1}));
    sbq.delete();
    repeat (4) @(negedge clock);
    reset_n = 1'b1;
    repeat (60) @(negedge clock);
    send(1'b0, 24'h000100, 2'd2, 32'h0, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
